// File: rtl/led_sched_pkg.sv
// +--------------------------------------------------------------------+
// | led_sched_pkg : shared types and helpers for the LED scheduler     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] PAT_OFF  = 2'b00;
  localparam logic [1:0] PAT_ON   = 2'b01;
  localparam logic [1:0] PAT_SLOW = 2'b10;
  localparam logic [1:0] PAT_FAST = 2'b11;

  // (a + b) mod n for operands already below n
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin one-hot pick                |
// | Option: LED_SCHED_PRIO0_EN gives requester 0 absolute priority     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import led_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  int w_pos;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    w_pos    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = wrap_add(int'(rr_ptr), k, N_REQ);
      if (!any && req[w_pos]) begin
        any         = 1'b1;
        pick[w_pos] = 1'b1;
        pick_idx    = IDX_W'(w_pos);
      end
    end
`ifdef LED_SCHED_PRIO0_EN
    if (req[0]) begin
      pick     = '0;
      pick[0]  = 1'b1;
      pick_idx = '0;
      any      = 1'b1;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/led_scheduler.sv
// +--------------------------------------------------------------------+
// | led_scheduler : time-slices one status LED among N_REQ requesters  |
// | Option: LED_SCHED_PRIO0_EN (requester 0 priority + preemption)     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module led_scheduler
  import led_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int SLOT_W   = 25,
  parameter int GAP_W    = 22,
  parameter int SLOW_BIT = 23,
  parameter int FAST_BIT = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] pattern,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               led
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t            r_state;
  logic [N_REQ-1:0]  r_grant;
  logic              r_busy;
  logic              r_led;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_owner;

  logic [N_REQ-1:0]  w_pick;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_any;
  logic [1:0]        w_pat;
  logic              w_led_val;
  logic              w_release;
  logic [IDX_W-1:0]  w_next_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req      (req),
    .rr_ptr   (r_rr_ptr),
    .pick     (w_pick),
    .pick_idx (w_pick_idx),
    .any      (w_any)
  );

  // Live pattern of the current owner; mid-slot changes show on the next update
  assign w_pat      = pattern[{r_owner, 1'b0} +: 2];
  assign w_next_ptr = IDX_W'(wrap_add(int'(r_owner), 1, N_REQ));

  always_comb begin
    w_led_val = 1'b0;
    case (w_pat)
      PAT_OFF:  w_led_val = 1'b0;
      PAT_ON:   w_led_val = 1'b1;
      PAT_SLOW: w_led_val = r_slot_cnt[SLOW_BIT];
      PAT_FAST: w_led_val = r_slot_cnt[FAST_BIT];
      default:  w_led_val = 1'b0;
    endcase
  end

  always_comb begin
    w_release = !req[r_owner];
`ifdef LED_SCHED_PRIO0_EN
    if (req[0] && (r_owner != '0)) w_release = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_led      <= 1'b0;
      r_slot_cnt <= '0;
      r_gap_cnt  <= '0;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_led <= 1'b0;
          if (w_any) begin
            r_state    <= SHOW;
            r_grant    <= w_pick;
            r_owner    <= w_pick_idx;
            r_slot_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        SHOW: begin
          r_led      <= w_led_val;
          r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
          // Slot end and early release collapse into one move to GAP
          if ((r_slot_cnt == '1) || w_release) begin
            r_state   <= GAP;
            r_grant   <= '0;
            r_rr_ptr  <= w_next_ptr;
            r_gap_cnt <= '0;
          end
        end
        GAP: begin
          r_led     <= 1'b0;
          r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          if (r_gap_cnt == '1) begin
            if (w_any) begin
              r_state    <= SHOW;
              r_grant    <= w_pick;
              r_owner    <= w_pick_idx;
              r_slot_cnt <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;
  assign led   = r_led;

endmodule

`default_nettype wire

// File: tb/tb_led_scheduler.sv
// +--------------------------------------------------------------------+
// | tb_led_scheduler : directed scoreboard bench for led_scheduler     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_led_scheduler;

  localparam int N_REQ    = 4;
  localparam int SLOT_W   = 4;
  localparam int GAP_W    = 2;
  localparam int SLOW_BIT = 3;
  localparam int FAST_BIT = 1;

  typedef struct {
    logic [N_REQ-1:0] g;
    logic             b;
    logic             l;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic [7:0]       pattern;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             led;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  led_scheduler #(
    .N_REQ    (N_REQ),
    .SLOT_W   (SLOT_W),
    .GAP_W    (GAP_W),
    .SLOW_BIT (SLOW_BIT),
    .FAST_BIT (FAST_BIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .pattern (pattern),
    .grant   (grant),
    .busy    (busy),
    .led     (led)
  );

  task automatic push(input logic [N_REQ-1:0] g, input logic b, input logic l, input int n);
    exp_t e;
    e.g = g;
    e.b = b;
    e.l = l;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      checks++;
      assert (grant === e.g) else begin
        errors++;
        $error("FAIL %s grant observed %b expected %b", tag, grant, e.g);
      end
      checks++;
      assert (busy === e.b) else begin
        errors++;
        $error("FAIL %s busy observed %b expected %b", tag, busy, e.b);
      end
      checks++;
      assert (led === e.l) else begin
        errors++;
        $error("FAIL %s led observed %b expected %b", tag, led, e.l);
      end
    end
  endtask

  task automatic check_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_now(tag);
    end
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [N_REQ-1:0] rr_seq [5];

  initial begin
`ifdef LED_SCHED_PRIO0_EN
    rr_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    rst     = 1'b0;
    req     = '0;
    pattern = 8'h55;
    @(posedge clk);
    #1;
    push('0, 1'b0, 1'b0, 1);
    check_now("reset_state");

    // Reset dropped mid-slot clears everything without a clock edge
    rst = 1'b1;
    req = 4'b0010;
    push(4'b0010, 1'b1, 1'b0, 1);
    push(4'b0010, 1'b1, 1'b1, 2);
    check_n(3, "rst_show");
    rst = 1'b0;
    #1;
    push('0, 1'b0, 1'b0, 1);
    check_now("rst_async");
    @(posedge clk);
    #1;
    push('0, 1'b0, 1'b0, 1);
    check_now("rst_hold");
    rst = 1'b1;
    push(4'b0010, 1'b1, 1'b0, 1);
    check_n(1, "rst_release");

    // Round robin with all requesters always on
    do_reset();
    pattern = 8'h55;
    req     = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      push(rr_seq[i], 1'b1, 1'b0, 1);
      push(rr_seq[i], 1'b1, 1'b1, 15);
      if (i < 4) begin
        push('0, 1'b1, 1'b1, 1);
        push('0, 1'b1, 1'b0, 3);
      end
    end
    check_n(96, "round_robin");

    // Slow blink then fast blink from requester 0
    do_reset();
    req     = 4'b0001;
    pattern = 8'b0000_0010;
    push(4'b0001, 1'b1, 1'b0, 1);
    for (int s = 0; s < 15; s++) push(4'b0001, 1'b1, 1'((s >> SLOW_BIT) & 1), 1);
    push('0, 1'b1, 1'b1, 1);
    push('0, 1'b1, 1'b0, 3);
    check_n(20, "slow_blink");
    pattern = 8'b0000_0011;
    push(4'b0001, 1'b1, 1'b0, 1);
    for (int s = 0; s < 15; s++) push(4'b0001, 1'b1, 1'((s >> FAST_BIT) & 1), 1);
    check_n(16, "fast_blink");
    req = '0;
    push('0, 1'b1, 1'b1, 1);
    push('0, 1'b1, 1'b0, 3);
    push('0, 1'b0, 1'b0, 1);
    check_n(5, "fast_end");

    // Early release of requester 2
    req     = 4'b0100;
    pattern = 8'b0001_0000;
    push(4'b0100, 1'b1, 1'b0, 1);
    push(4'b0100, 1'b1, 1'b1, 4);
    check_n(5, "early_show");
    req = '0;
    push('0, 1'b1, 1'b1, 1);
    push('0, 1'b1, 1'b0, 3);
    push('0, 1'b0, 1'b0, 2);
    check_n(6, "early_gap");

    // Pointer wrap: owner 3 finishes, requester 0 is next
    req     = 4'b1000;
    pattern = 8'b0100_0000;
    push(4'b1000, 1'b1, 1'b0, 1);
    check_n(1, "wrap_start");
    req = 4'b1001;
`ifdef LED_SCHED_PRIO0_EN
    push('0, 1'b1, 1'b1, 1);
    push('0, 1'b1, 1'b0, 3);
    push(4'b0001, 1'b1, 1'b0, 1);
    check_n(5, "wrap_preempt");
`else
    push(4'b1000, 1'b1, 1'b1, 15);
    push('0, 1'b1, 1'b1, 1);
    push('0, 1'b1, 1'b0, 3);
    push(4'b0001, 1'b1, 1'b0, 1);
    check_n(20, "wrap");
`endif

    // Requester 0 rises during requester 1's slot
    do_reset();
    pattern = 8'h55;
    req     = 4'b0010;
    push(4'b0010, 1'b1, 1'b0, 1);
    push(4'b0010, 1'b1, 1'b1, 2);
    check_n(3, "pre_show");
    req = 4'b0011;
`ifdef LED_SCHED_PRIO0_EN
    push('0, 1'b1, 1'b1, 1);
    push('0, 1'b1, 1'b0, 3);
    push(4'b0001, 1'b1, 1'b0, 1);
    check_n(5, "preempt");
`else
    push(4'b0010, 1'b1, 1'b1, 13);
    push('0, 1'b1, 1'b1, 1);
    push('0, 1'b1, 1'b0, 3);
    push(4'b0001, 1'b1, 1'b0, 1);
    check_n(18, "no_preempt");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_scheduler.md
# led_scheduler

Time-slicing controller that shares the board's single status LED among N_REQ requesters. Each requester asserts a request plus a 2-bit pattern code. The block grants the LED round-robin for a fixed slot and drives the LED from a slot-local phase counter. It sits between the user logic (status sources) and the LED pin, clocked from `clk` with the reset from the user reset primitive.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `SLOT_W`, default 25: slot length = 2^SLOT_W cycles.
- `GAP_W`, default 22: LED-off separator = 2^GAP_W cycles.
- `SLOW_BIT`, default 23: slot-counter bit driving slow blink; must be < SLOT_W.
- `FAST_BIT`, default 21: slot-counter bit driving fast blink; must be < SLOW_BIT.

- `clk` in, 1: single clock.
- `rst` in, 1: asynchronous, active-low reset.
- `req` in, N_REQ: per-requester LED request, level-sensitive.
- `pattern` in, 2*N_REQ: code for requester i at [2i+1:2i]. 00 = off, 01 = on, 10 = slow blink, 11 = fast blink.
- `grant` out, N_REQ: one-hot owner of current slot; 0 when no owner.
- `busy` out, 1: high in SHOW and GAP.
- `led` out, 1: LED drive, active-high.

## Operation
- States:
  - IDLE: no owner.
  - SHOW: slot running.
  - GAP: separator, LED forced off.
- Reset (async, rst=0): state=IDLE, grant=0, busy=0, led=0, slot_cnt=0, gap_cnt=0, rr_ptr=0.
- Arbitration happens in IDLE, and on the last GAP cycle. It picks the first asserted req scanning from index rr_ptr upward, wrapping modulo N_REQ.
- IDLE, any req=1: go to SHOW, set grant to the winner, clear slot_cnt. With no req, stay in IDLE.
- SHOW:
  - slot_cnt increments by 1 each cycle and is SLOT_W bits wide.
  - Exit to GAP when slot_cnt = 2^SLOT_W−1, or when the granted req is 0 (early release).
  - On exit: grant=0, rr_ptr = granted index + 1 mod N_REQ, clear gap_cnt.
- GAP:
  - gap_cnt increments each cycle.
  - At gap_cnt = 2^GAP_W−1, arbitrate. Any req goes to SHOW; none goes to IDLE.
- LED value in SHOW uses the granted requester's live pattern:
  - 00 → 0
  - 01 → 1
  - 10 → slot_cnt[SLOW_BIT]
  - 11 → slot_cnt[FAST_BIT]
- LED is 0 in IDLE and GAP.
- Pattern changes mid-slot take effect on the next LED update. They do not restart the slot.
- Req of non-granted requesters is ignored until the next arbitration.
- Simultaneous slot end and req drop: one transition to GAP. rr_ptr advances as normal.
- Reset asserted mid-slot: immediate return to reset values. No partial slot is resumed.

## Timing
- grant, busy, state: registered. Visible the cycle after the arbitration condition.
- led: registered, one cycle behind grant/slot_cnt. First SHOW cycle shows led=0. Last slot pattern value appears on the first GAP cycle, then 0.
- Slot occupies exactly 2^SLOT_W cycles of grant≠0 unless released early.
- Back-to-back requesters are separated by exactly 2^GAP_W cycles of grant=0.
- Early release: req falls in cycle t, grant=0 at t+1.

## Configuration
- `LED_SCHED_PRIO0_EN` defined:
  - requester 0 wins every arbitration when asserted, regardless of rr_ptr.
  - If req[0] rises during another requester's SHOW, that slot ends next cycle (to GAP, rr_ptr advanced past the preempted index). Requester 0 is then granted at GAP end.
- Undefined: pure round-robin, no preemption.

## Structure
- Package `led_sched_pkg`:
  - state enum: IDLE, SHOW, GAP.
  - pattern code constants: PAT_OFF, PAT_ON, PAT_SLOW, PAT_FAST.
- Sub-module `rr_arbiter`: combinational one-hot pick from req and rr_ptr, with the optional priority-0 override under the macro.
- Counters, FSM and LED register live in `led_scheduler`.

## Test plan
Bench parameters: SLOT_W=4, GAP_W=2, SLOW_BIT=3, FAST_BIT=1, N_REQ=4.
- Reset: drop rst mid-SHOW → grant=0, busy=0, led=0 immediately. Release rst, req=0010 → grant=0010 one cycle later.
- Round robin: req=1111, all patterns 01 → grant 0001, 0010, 0100, 1000, 0001. Each lasts 16 cycles with 4 cycles grant=0 between. led=1 during slots (one-cycle lag), 0 in gaps.
- Patterns: single req[0] with pattern 10 → within a slot led 0 for 8 cycles, then 1 for 8 (lagged one cycle). Pattern 11 → led period 4 cycles, 2 high / 2 low.
- Early release: req=0100 alone, drop req[2] after 5 SHOW cycles → grant=0 next cycle, busy=1 for 4 GAP cycles, then IDLE with busy=0.
- Pointer wrap: grant=1000 slot completes with req=1001 → next grant 0001.
- Macro on: requester 1 in SHOW, req[0] rises → grant=0 next cycle, 4 gap cycles, then grant=0001. Macro off: the same stimulus leaves requester 1's slot running to 16 cycles.
